// File: rtl/alu_rs_pkg.sv
// Shared types for the Tomasulo-style ALU reservation station: operation
// class, CDB broadcast word, issue word and the per-entry record.
package tomasula_types;

    localparam int RS_DEPTH = 4;
    localparam int TAG_W    = 3;
    localparam int XLEN     = 32;

    typedef enum logic [1:0] {
        ARITH  = 2'd0,
        BRANCH = 2'd1,
        MEMORY = 2'd2,
        SYSTEM = 2'd3
    } op_t;

    typedef struct packed {
        logic             req;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } cdb_data;

    typedef struct packed {
        logic             load;
        op_t              op;
        logic [2:0]       funct3;
        logic             funct7;
        logic [XLEN-1:0]  src1_data;
        logic [XLEN-1:0]  src2_data;
        logic [TAG_W-1:0] tag;
    } alu_word;

    typedef struct packed {
        logic             rdy;
        logic [XLEN-1:0]  val;
        logic [TAG_W-1:0] tag;
    } rs_src_t;

    typedef struct packed {
        logic             busy;
        op_t              op;
        logic [2:0]       funct3;
        logic             funct7;
        rs_src_t          src1;
        rs_src_t          src2;
        logic [TAG_W-1:0] dest_tag;
    } rs_entry_t;

    // A waiting operand picks up the broadcast value when the bus carries
    // its producer's tag; an operand that is already ready is left alone.
    function automatic rs_src_t src_snoop(rs_src_t s, cdb_data c);
        rs_src_t r;
        r = s;
        if (!s.rdy && c.req && (c.tag == s.tag)) begin
            r.rdy = 1'b1;
            r.val = c.data;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-index set-bit finder; shared by free-slot and ready-entry selection.
module rs_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched operations until both operands
// are known (directly or via CDB snooping), then issues the lowest-index
// ready entry into a single-stage issue register with valid/ack handshake.
module alu_rs
    import tomasula_types::*;
#(
    parameter int RS_DEPTH = tomasula_types::RS_DEPTH,
    parameter int TAG_W    = tomasula_types::TAG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    disp_valid,
    input  op_t                     disp_op,
    input  logic [2:0]              disp_funct3,
    input  logic                    disp_funct7,
    input  logic                    disp_src1_rdy,
    input  logic                    disp_src2_rdy,
    input  logic [31:0]             disp_src1_val,
    input  logic [31:0]             disp_src2_val,
    input  logic [TAG_W-1:0]        disp_src1_tag,
    input  logic [TAG_W-1:0]        disp_src2_tag,
    input  logic [TAG_W-1:0]        disp_dest_tag,
    output logic                    rs_full,
    input  cdb_data                 cdb_in,
    input  logic                    issue_ack,
    output tomasula_types::alu_word alu_word
);

    localparam int SEL_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    rs_entry_t               ent_q [RS_DEPTH];
    rs_entry_t               ent_d [RS_DEPTH];
    rs_entry_t               disp_ent;
    tomasula_types::alu_word issue_q;
    tomasula_types::alu_word issue_d;

    logic [RS_DEPTH-1:0] busy_vec;
    logic [RS_DEPTH-1:0] free_vec;
    logic [RS_DEPTH-1:0] ready_vec;
    logic [SEL_W-1:0]    free_idx;
    logic [SEL_W-1:0]    sel_idx;
    logic                free_found;
    logic                sel_found;
    logic                disp_fire;
    logic                load_en;
    logic                issue_fire;

    // Occupancy and eligibility come from registered state only, so a
    // same-cycle wakeup or issue never feeds back into this cycle's choice.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            free_vec[i]  = ~ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy & ent_q[i].src1.rdy & ent_q[i].src2.rdy;
        end
    end

    rs_prio_enc #(
        .N     (RS_DEPTH),
        .IDX_W (SEL_W)
    ) u_free_sel (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_prio_enc #(
        .N     (RS_DEPTH),
        .IDX_W (SEL_W)
    ) u_ready_sel (
        .req   (ready_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign rs_full    = &busy_vec;
    assign disp_fire  = disp_valid & ~rs_full & free_found;
    assign load_en    = ~issue_q.load | issue_ack;
    assign issue_fire = load_en & sel_found;
    assign alu_word   = issue_q;

    // Build the incoming entry, snooping the CDB so a producer finishing in
    // the dispatch cycle is not missed.
    always_comb begin
        disp_ent          = '0;
        disp_ent.busy     = 1'b1;
        disp_ent.op       = disp_op;
        disp_ent.funct3   = disp_funct3;
        disp_ent.funct7   = disp_funct7;
        disp_ent.src1.rdy = disp_src1_rdy;
        disp_ent.src1.val = disp_src1_val;
        disp_ent.src1.tag = disp_src1_tag;
        disp_ent.src2.rdy = disp_src2_rdy;
        disp_ent.src2.val = disp_src2_val;
        disp_ent.src2.tag = disp_src2_tag;
        disp_ent.dest_tag = disp_dest_tag;
        disp_ent.src1     = src_snoop(disp_ent.src1, cdb_in);
        disp_ent.src2     = src_snoop(disp_ent.src2, cdb_in);
    end

    // Entry next state: wakeup, issue release, dispatch write; flush wins.
    // The dispatch slot is chosen among entries free before this edge, so a
    // slot vacated by this cycle's issue is never the target.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                ent_d[i].src1 = src_snoop(ent_q[i].src1, cdb_in);
                ent_d[i].src2 = src_snoop(ent_q[i].src2, cdb_in);
            end
        end
        if (issue_fire) begin
            ent_d[sel_idx].busy = 1'b0;
        end
        if (disp_fire) begin
            ent_d[free_idx] = disp_ent;
        end
        if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_d[i].busy = 1'b0;
            end
        end
    end

    // Issue register next state: load the selected entry when the slot is
    // empty or being consumed; with nothing eligible only the valid drops.
    always_comb begin
        issue_d = issue_q;
        if (flush) begin
            issue_d.load = 1'b0;
        end else if (load_en) begin
            if (sel_found) begin
                issue_d.load      = 1'b1;
                issue_d.op        = ent_q[sel_idx].op;
                issue_d.funct3    = ent_q[sel_idx].funct3;
                issue_d.funct7    = ent_q[sel_idx].funct7;
                issue_d.src1_data = ent_q[sel_idx].src1.val;
                issue_d.src2_data = ent_q[sel_idx].src2.val;
                issue_d.tag       = ent_q[sel_idx].dest_tag;
            end else begin
                issue_d.load = 1'b0;
            end
        end
    end

    // State registers; reset discards every entry and empties the issue word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            issue_q <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            issue_q <= issue_d;
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios with fixed expectations
// followed by a randomized run compared against a behavioural model.
module tb_alu_rs;
    import tomasula_types::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    op_t         disp_op;
    logic [2:0]  disp_funct3;
    logic        disp_funct7;
    logic        disp_src1_rdy;
    logic        disp_src2_rdy;
    logic [31:0] disp_src1_val;
    logic [31:0] disp_src2_val;
    logic [2:0]  disp_src1_tag;
    logic [2:0]  disp_src2_tag;
    logic [2:0]  disp_dest_tag;
    logic        rs_full;
    cdb_data     cdb;
    logic        issue_ack;
    alu_word     alu_out;

    int tests;
    int fails;

    alu_rs dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_op       (disp_op),
        .disp_funct3   (disp_funct3),
        .disp_funct7   (disp_funct7),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_src1_val (disp_src1_val),
        .disp_src2_val (disp_src2_val),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_tag (disp_src2_tag),
        .disp_dest_tag (disp_dest_tag),
        .rs_full       (rs_full),
        .cdb_in        (cdb),
        .issue_ack     (issue_ack),
        .alu_word      (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    rs_entry_t m_ent [RS_DEPTH];
    alu_word   m_iss;

    task automatic model_reset();
        for (int i = 0; i < RS_DEPTH; i++) m_ent[i] = '0;
        m_iss = '0;
    endtask

    function automatic bit model_full();
        bit f;
        f = 1'b1;
        for (int i = 0; i < RS_DEPTH; i++) if (!m_ent[i].busy) f = 1'b0;
        return f;
    endfunction

    // Advance the model by one clock edge using the inputs applied right now.
    task automatic model_step();
        bit full;
        int sel;
        int fr;
        if (!rst) begin
            model_reset();
            return;
        end
        full = model_full();
        sel = -1;
        fr  = -1;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (sel < 0 && m_ent[i].busy && m_ent[i].src1.rdy && m_ent[i].src2.rdy) sel = i;
            if (fr < 0 && !m_ent[i].busy) fr = i;
        end
        if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) m_ent[i].busy = 1'b0;
            m_iss.load = 1'b0;
            return;
        end
        if (!m_iss.load || issue_ack) begin
            if (sel >= 0) begin
                m_iss.load      = 1'b1;
                m_iss.op        = m_ent[sel].op;
                m_iss.funct3    = m_ent[sel].funct3;
                m_iss.funct7    = m_ent[sel].funct7;
                m_iss.src1_data = m_ent[sel].src1.val;
                m_iss.src2_data = m_ent[sel].src2.val;
                m_iss.tag       = m_ent[sel].dest_tag;
                m_ent[sel].busy = 1'b0;
            end else begin
                m_iss.load = 1'b0;
            end
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (m_ent[i].busy && cdb.req) begin
                if (!m_ent[i].src1.rdy && m_ent[i].src1.tag == cdb.tag) begin
                    m_ent[i].src1.rdy = 1'b1;
                    m_ent[i].src1.val = cdb.data;
                end
                if (!m_ent[i].src2.rdy && m_ent[i].src2.tag == cdb.tag) begin
                    m_ent[i].src2.rdy = 1'b1;
                    m_ent[i].src2.val = cdb.data;
                end
            end
        end
        if (disp_valid && !full && fr >= 0) begin
            m_ent[fr].busy     = 1'b1;
            m_ent[fr].op       = disp_op;
            m_ent[fr].funct3   = disp_funct3;
            m_ent[fr].funct7   = disp_funct7;
            m_ent[fr].dest_tag = disp_dest_tag;
            m_ent[fr].src1.tag = disp_src1_tag;
            m_ent[fr].src2.tag = disp_src2_tag;
            m_ent[fr].src1.rdy = disp_src1_rdy || (cdb.req && cdb.tag == disp_src1_tag);
            m_ent[fr].src2.rdy = disp_src2_rdy || (cdb.req && cdb.tag == disp_src2_tag);
            m_ent[fr].src1.val = disp_src1_rdy ? disp_src1_val : cdb.data;
            m_ent[fr].src2.val = disp_src2_rdy ? disp_src2_val : cdb.data;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush         = 1'b0;
        disp_valid    = 1'b0;
        disp_op       = ARITH;
        disp_funct3   = 3'd0;
        disp_funct7   = 1'b0;
        disp_src1_rdy = 1'b0;
        disp_src2_rdy = 1'b0;
        disp_src1_val = 32'd0;
        disp_src2_val = 32'd0;
        disp_src1_tag = 3'd0;
        disp_src2_tag = 3'd0;
        disp_dest_tag = 3'd0;
        cdb           = '0;
        issue_ack     = 1'b0;
    endtask

    task automatic set_disp(input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [2:0] t2,
                            input logic [2:0] dest);
        disp_valid    = 1'b1;
        disp_op       = ARITH;
        disp_funct3   = 3'd0;
        disp_funct7   = 1'b0;
        disp_src1_rdy = r1;
        disp_src1_val = v1;
        disp_src1_tag = t1;
        disp_src2_rdy = r2;
        disp_src2_val = v2;
        disp_src2_tag = t2;
        disp_dest_tag = dest;
    endtask

    task automatic clean();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        tick();
        tick();
        tests++;
        if (rs_full !== 1'b0) begin
            fails++; $display("FAIL reset_full: got %b want 0", rs_full);
        end
        tests++;
        if (alu_out !== '0) begin
            fails++; $display("FAIL reset_word: got %h want 0", alu_out);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        clean();
        issue_ack = 1'b1;
        set_disp(1'b1, 32'd5, 3'd0, 1'b1, 32'd7, 3'd0, 3'd2);
        tick();
        disp_valid = 1'b0;
        tests++;
        if (alu_out.load !== 1'b0) begin
            fails++; $display("FAIL basic_early: load got %b want 0", alu_out.load);
        end
        tick();
        tests++;
        if (alu_out.load !== 1'b1 || alu_out.src1_data !== 32'd5 ||
            alu_out.src2_data !== 32'd7 || alu_out.tag !== 3'd2 || alu_out.op !== ARITH) begin
            fails++; $display("FAIL basic_issue: got %h want load=1 s1=5 s2=7 tag=2", alu_out);
        end
        tick();
        tests++;
        if (alu_out.load !== 1'b0) begin
            fails++; $display("FAIL basic_drain: load got %b want 0", alu_out.load);
        end
    endtask

    task automatic test_wakeup();
        clean();
        issue_ack = 1'b1;
        set_disp(1'b1, 32'd1, 3'd0, 1'b0, 32'd0, 3'd3, 3'd5);
        tick();
        disp_valid = 1'b0;
        tick();
        tick();
        tests++;
        if (alu_out.load !== 1'b0) begin
            fails++; $display("FAIL wakeup_wait: load got %b want 0", alu_out.load);
        end
        cdb.req = 1'b1; cdb.tag = 3'd3; cdb.data = 32'h10;
        tick();
        cdb = '0;
        tests++;
        if (alu_out.load !== 1'b0) begin
            fails++; $display("FAIL wakeup_same: load got %b want 0", alu_out.load);
        end
        tick();
        tests++;
        if (alu_out.load !== 1'b1 || alu_out.src2_data !== 32'h10 || alu_out.tag !== 3'd5) begin
            fails++; $display("FAIL wakeup_issue: got %h want load=1 s2=10 tag=5", alu_out);
        end
        tick();
    endtask

    task automatic test_dispatch_capture();
        clean();
        issue_ack = 1'b1;
        set_disp(1'b0, 32'd0, 3'd4, 1'b1, 32'd2, 3'd0, 3'd6);
        cdb.req = 1'b1; cdb.tag = 3'd4; cdb.data = 32'd9;
        tick();
        disp_valid = 1'b0;
        cdb = '0;
        tick();
        tests++;
        if (alu_out.load !== 1'b1 || alu_out.src1_data !== 32'd9 || alu_out.tag !== 3'd6) begin
            fails++; $display("FAIL capture_issue: got %h want load=1 s1=9 tag=6", alu_out);
        end
        tick();
    endtask

    task automatic test_full();
        logic [2:0] got [$];
        clean();
        issue_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_disp(1'b0, 32'd0, 3'(i + 1), 1'b1, 32'd3, 3'd0, 3'(i));
            tick();
            if (i == 3) begin
                tests++;
                if (rs_full !== 1'b1) begin
                    fails++; $display("FAIL full_set: got %b want 1", rs_full);
                end
            end
        end
        disp_valid = 1'b0;
        tests++;
        if (rs_full !== 1'b1) begin
            fails++; $display("FAIL full_drop: got %b want 1", rs_full);
        end
        cdb.req = 1'b1; cdb.tag = 3'd1; cdb.data = 32'hAA;
        tick();
        cdb = '0;
        tick();
        tests++;
        if (rs_full !== 1'b0 || alu_out.load !== 1'b1 || alu_out.tag !== 3'd0 ||
            alu_out.src1_data !== 32'hAA) begin
            fails++; $display("FAIL full_free: full=%b word=%h want full=0 load=1 tag=0 s1=aa",
                              rs_full, alu_out);
        end
        issue_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                cdb.req = 1'b1; cdb.tag = 3'(c + 2); cdb.data = 32'(c);
            end else begin
                cdb = '0;
            end
            tick();
            if (alu_out.load === 1'b1) got.push_back(alu_out.tag);
        end
        tests++;
        if (got.size() != 3 || got[0] !== 3'd1 || got[1] !== 3'd2 || got[2] !== 3'd3) begin
            fails++; $display("FAIL full_order: got %0d issues %p want tags 1,2,3", got.size(), got);
        end
    endtask

    task automatic test_hold();
        alu_word exp_a;
        clean();
        issue_ack = 1'b0;
        set_disp(1'b1, 32'h11, 3'd0, 1'b1, 32'h22, 3'd0, 3'd1);
        tick();
        set_disp(1'b1, 32'h33, 3'd0, 1'b1, 32'h44, 3'd0, 3'd3);
        tick();
        disp_valid = 1'b0;
        exp_a = '0;
        exp_a.load = 1'b1; exp_a.op = ARITH; exp_a.funct3 = 3'd0; exp_a.funct7 = 1'b0;
        exp_a.src1_data = 32'h11; exp_a.src2_data = 32'h22; exp_a.tag = 3'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (alu_out !== exp_a) begin
                fails++; $display("FAIL hold_c%0d: got %h want %h", c, alu_out, exp_a);
            end
        end
        issue_ack = 1'b1;
        tick();
        tests++;
        if (alu_out.load !== 1'b1 || alu_out.tag !== 3'd3 || alu_out.src1_data !== 32'h33 ||
            alu_out.src2_data !== 32'h44) begin
            fails++; $display("FAIL hold_ack: got %h want load=1 tag=3 s1=33 s2=44", alu_out);
        end
        tick();
        tests++;
        if (alu_out.load !== 1'b0) begin
            fails++; $display("FAIL hold_drain: load got %b want 0", alu_out.load);
        end
    endtask

    task automatic test_flush_reset();
        clean();
        issue_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_disp(1'b1, 32'(i), 3'd0, 1'b1, 32'(i), 3'd0, 3'(i + 1));
            tick();
        end
        tests++;
        if (alu_out.load !== 1'b1 || rs_full !== 1'b0) begin
            fails++; $display("FAIL flush_pre: load=%b full=%b want 1 0", alu_out.load, rs_full);
        end
        flush = 1'b1;
        issue_ack = 1'b1;
        set_disp(1'b1, 32'd8, 3'd0, 1'b1, 32'd8, 3'd0, 3'd7);
        cdb.req = 1'b1; cdb.tag = 3'd0; cdb.data = 32'd1;
        tick();
        idle_inputs();
        issue_ack = 1'b1;
        tests++;
        if (rs_full !== 1'b0 || alu_out.load !== 1'b0) begin
            fails++; $display("FAIL flush_clear: full=%b load=%b want 0 0", rs_full, alu_out.load);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (alu_out.load !== 1'b0) begin
                fails++; $display("FAIL flush_after_c%0d: load got %b want 0", c, alu_out.load);
            end
        end
        issue_ack = 1'b0;
        set_disp(1'b1, 32'd1, 3'd0, 1'b1, 32'd2, 3'd0, 3'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_disp(1'b0, 32'd0, 3'd6, 1'b1, 32'd0, 3'd0, 3'(i + 2));
            tick();
        end
        disp_valid = 1'b0;
        tests++;
        if (rs_full !== 1'b1 || alu_out.load !== 1'b1) begin
            fails++; $display("FAIL reset_pre: full=%b load=%b want 1 1", rs_full, alu_out.load);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if (rs_full !== 1'b0 || alu_out !== '0) begin
            fails++; $display("FAIL reset_async: full=%b word=%h want 0 0", rs_full, alu_out);
        end
        #1;
        rst = 1'b1;
        issue_ack = 1'b1;
        cdb.req = 1'b1; cdb.tag = 3'd6; cdb.data = 32'h5A;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests++;
            if (alu_out.load !== 1'b0) begin
                fails++; $display("FAIL reset_discard_c%0d: load got %b want 0", c, alu_out.load);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        clean();
        for (int c = 0; c < 1500; c++) begin
            flush         = ($urandom_range(0, 99) < 3);
            disp_valid    = ($urandom_range(0, 9) < 6);
            disp_op       = op_t'($urandom_range(0, 3));
            disp_funct3   = 3'($urandom_range(0, 7));
            disp_funct7   = 1'($urandom_range(0, 1));
            disp_src1_rdy = 1'($urandom_range(0, 1));
            disp_src2_rdy = 1'($urandom_range(0, 1));
            disp_src1_val = $urandom;
            disp_src2_val = $urandom;
            disp_src1_tag = 3'($urandom_range(0, 7));
            disp_src2_tag = 3'($urandom_range(0, 7));
            disp_dest_tag = 3'($urandom_range(0, 7));
            cdb.req       = 1'($urandom_range(0, 1));
            cdb.tag       = 3'($urandom_range(0, 7));
            cdb.data      = $urandom;
            issue_ack     = ($urandom_range(0, 9) < 6);
            tick();
            tests++;
            if (rs_full !== model_full()) begin
                fails++; $display("FAIL rand_full_c%0d: got %b want %b", c, rs_full, model_full());
            end
            tests++;
            if (alu_out.load !== m_iss.load) begin
                fails++; $display("FAIL rand_load_c%0d: got %b want %b", c, alu_out.load, m_iss.load);
            end else if (m_iss.load && alu_out !== m_iss) begin
                fails++; $display("FAIL rand_word_c%0d: got %h want %h", c, alu_out, m_iss);
            end
        end
        idle_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        rst = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_wakeup();
        test_dispatch_capture();
        test_full();
        test_hold();
        test_flush_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
